// File: rtl/exu_gpr_acc_if.sv
// GPR register-file port bundle.
// The accessor drives the read/write address and data; the file returns the read data.
interface exu_gpr_if_t #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic            wen;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  modport mst (
    output ra1, ra2, wen, wa, wd,
    input  rd1, rd2
  );

  modport slv (
    input  ra1, ra2, wen, wa, wd,
    output rd1, rd2
  );
endinterface

// File: rtl/exu_gpr_acc.sv
// Single-register GPR accessor for the debug path.
// It arbitrates for one GPR mux channel and gives up with an error if no grant arrives in time.
module exu_gpr_acc #(
  parameter int XLEN        = 32,
  parameter int AW          = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            chn_req,
  input  logic            chn_gnt,
  exu_gpr_if_t.mst        gpr_mst
);

  localparam int CW = (TIMEOUT_CYC == 0) ? 1
                    : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM =
    CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic unused_rd2;
  assign unused_rd2 = ^gpr_mst.rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_rdy     = 1'b0;
    rsp_vld     = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    chn_req     = 1'b0;
    gpr_mst.ra1 = '0;
    gpr_mst.ra2 = '0;
    gpr_mst.wa  = '0;
    gpr_mst.wd  = '0;
    gpr_mst.wen = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = ARB;
        end
      end
      ARB: begin
        chn_req     = 1'b1;
        gpr_mst.ra1 = addr_q;
        gpr_mst.wa  = addr_q;
        gpr_mst.wd  = wdata_q;
        gpr_mst.wen = wr_q;
        if (chn_gnt) begin
          // x0 reads as zero regardless of what the file returns
          rdata_d = (wr_q || addr_q == '0) ? '0
                  : gpr_mst.rd1;
          err_d   = 1'b0;
          state_d = RSP;
        end else begin
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          if (TIMEOUT_CYC != 0 && cnt_q == TO_LIM) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RSP;
          end
        end
      end
      RSP: begin
        rsp_vld   = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exu_gpr_acc.sv
// Directed bench for exu_gpr_acc.
// A small register-file model stands in for the GPR mux channel.
module tb_exu_gpr_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        chn_req;
  logic        chn_gnt;
  logic        ld;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [32];

  exu_gpr_if_t #(.XLEN(32), .AW(5)) gpr ();

  exu_gpr_acc #(.XLEN(32), .AW(5), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .chn_req   (chn_req),
    .chn_gnt   (chn_gnt),
    .gpr_mst   (gpr.mst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'h0 : {4{i[7:0]}};
    end else if (chn_gnt && gpr.wen && gpr.wa != 5'd0) begin
      regs[gpr.wa] <= gpr.wd;
    end
  end

  assign gpr.rd1 = (gpr.ra1 == 5'd0) ? 32'h0 : regs[gpr.ra1];
  assign gpr.rd2 = (gpr.ra2 == 5'd0) ? 32'h0 : regs[gpr.ra2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr,
                       input logic [4:0] a,
                       input logic [31:0] d);
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    chk("req_rdy_at_accept", {31'b0, req_rdy}, 32'd1);
    tick();
    req_vld   = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    int n;
    int arb;
    rst_n     = 1'b0;
    ld        = 1'b1;
    req_vld   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_rdy   = 1'b1;
    chn_gnt   = 1'b0;
    tick();
    tick();
    ld = 1'b0;
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("rst_chn_req", {31'b0, chn_req}, 32'd0);
    chk("rst_wen", {31'b0, gpr.wen}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // write x5, grant held high
    chn_gnt = 1'b1;
    issue(1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("w5_chn_req", {31'b0, chn_req}, 32'd1);
    chk("w5_wen", {31'b0, gpr.wen}, 32'd1);
    chk("w5_wa", {27'b0, gpr.wa}, 32'd5);
    chk("w5_wd", gpr.wd, 32'hDEAD_BEEF);
    tick();
    chk("w5_rsp_vld", {31'b0, rsp_vld}, 32'd1);
    chk("w5_err", {31'b0, rsp_err}, 32'd0);
    chk("w5_rdata", rsp_rdata, 32'd0);
    chk("w5_req_rdy", {31'b0, req_rdy}, 32'd0);
    tick();
    chk("w5_idle_vld", {31'b0, rsp_vld}, 32'd0);

    // read back x5
    issue(1'b0, 5'd5, 32'h0);
    chk("r5_ra1", {27'b0, gpr.ra1}, 32'd5);
    chk("r5_wen", {31'b0, gpr.wen}, 32'd0);
    tick();
    chk("r5_rsp_vld", {31'b0, rsp_vld}, 32'd1);
    chk("r5_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // x0 write then read
    issue(1'b1, 5'd0, 32'h1234);
    tick();
    chk("w0_err", {31'b0, rsp_err}, 32'd0);
    tick();
    issue(1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_rdata", rsp_rdata, 32'd0);
    chk("r0_err", {31'b0, rsp_err}, 32'd0);
    tick();

    // read x7 with 3 ungranted ARB cycles
    chn_gnt = 1'b0;
    issue(1'b0, 5'd7, 32'h0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (chn_req) n++;
      chk("r7_wait_vld", {31'b0, rsp_vld}, 32'd0);
      tick();
    end
    chn_gnt = 1'b1;
    if (chn_req) n++;
    tick();
    if (chn_req) n++;
    chk("r7_chn_req_cnt", n, 32'd4);
    chk("r7_rsp_vld", {31'b0, rsp_vld}, 32'd1);
    chk("r7_rdata", rsp_rdata, 32'h0707_0707);
    chk("r7_err", {31'b0, rsp_err}, 32'd0);
    tick();

    // grant timeout on write x12
    chn_gnt = 1'b0;
    issue(1'b1, 5'd12, 32'h0000_ABCD);
    arb = 0;
    while (!rsp_vld && arb < 40) begin
      arb++;
      tick();
    end
    chk("to_arb_cycles", arb, 32'd16);
    chk("to_rsp_vld", {31'b0, rsp_vld}, 32'd1);
    chk("to_err", {31'b0, rsp_err}, 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_x12", regs[12], 32'h0C0C_0C0C);
    tick();
    chk("to_idle", {31'b0, req_rdy}, 32'd1);

    // response backpressure
    chn_gnt = 1'b1;
    rsp_rdy = 1'b0;
    issue(1'b0, 5'd5, 32'h0);
    tick();
    req_vld = 1'b1;
    req_wr  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", {31'b0, rsp_vld}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_req_rdy", {31'b0, req_rdy}, 32'd0);
      chk("bp_wen", {31'b0, gpr.wen}, 32'd0);
      tick();
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    chk("bp_release", {31'b0, rsp_vld}, 32'd0);

    // reset during ARB of write x9
    chn_gnt = 1'b0;
    issue(1'b1, 5'd9, 32'h0000_00FF);
    chk("rst_arb_pre", {31'b0, chn_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_arb_chn_req", {31'b0, chn_req}, 32'd0);
    chk("rst_arb_wen", {31'b0, gpr.wen}, 32'd0);
    chk("rst_arb_req_rdy", {31'b0, req_rdy}, 32'd1);
    chn_gnt = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 5'd9, 32'h0);
    tick();
    chk("rst_x9", rsp_rdata, 32'h0909_0909);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
